// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the set-associative cache and its PLRU store.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WBACK,
        FILL,
        WTHRU
    } state_t;

    localparam int LINE_W = 128;
    localparam int WORD_W = 32;
    localparam int ADDR_W = 30;

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int sets);
        return ADDR_W - 2 - $clog2(sets);
    endfunction

    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/cache_plru.sv
// Per-set pseudo-LRU state: touch points the tree away from the accessed way,
// victim_way reports the way the tree currently points at.
module cache_plru
    import cache_pkg::*;
#(
    parameter int WAYS = 2,
    parameter int SETS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    touch,
    input  logic [idx_w(SETS)-1:0]  set_idx,
    input  logic [way_w(WAYS)-1:0]  touch_way,
    output logic [way_w(WAYS)-1:0]  victim_way
);

    generate
        if (WAYS == 4) begin : g_tree4
            // bit0 selects the half, bit1/bit2 select within the left/right pair
            logic [2:0] tree [SETS];
            logic [2:0] cur;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int unsigned s = 0; s < SETS; s++) tree[s] <= '0;
                end else if (touch) begin
                    tree[set_idx][0] <= ~touch_way[1];
                    if (touch_way[1]) tree[set_idx][2] <= ~touch_way[0];
                    else              tree[set_idx][1] <= ~touch_way[0];
                end
            end

            assign cur        = tree[set_idx];
            assign victim_way = cur[0] ? {1'b1, cur[2]} : {1'b0, cur[1]};
        end else if (WAYS == 2) begin : g_tree2
            logic bits_q [SETS];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int unsigned s = 0; s < SETS; s++) bits_q[s] <= 1'b0;
                end else if (touch) begin
                    bits_q[set_idx] <= ~touch_way[0];
                end
            end

            assign victim_way = bits_q[set_idx];
        end else begin : g_direct
            assign victim_way = '0;
        end
    endgenerate

endmodule

// File: rtl/assoc_wb_cache.sv
// N-way set-associative cache with PLRU replacement, write-back or write-through
// (both write-allocate), 128-bit line transfers and saturating hit/miss counters.
module assoc_wb_cache
    import cache_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SETS       = 8,
    parameter int WRITE_BACK = 1,
    parameter int STAT_W     = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                proc_read,
    input  logic                proc_write,
    input  logic [29:0]         proc_addr,
    input  logic [31:0]         proc_wdata,
    output logic [31:0]         proc_rdata,
    output logic                proc_stall,
    output logic                mem_read,
    output logic                mem_write,
    output logic [27:0]         mem_addr,
    output logic [127:0]        mem_wdata,
    input  logic [127:0]        mem_rdata,
    input  logic                mem_ready,
    output logic [STAT_W-1:0]   stat_hits,
    output logic [STAT_W-1:0]   stat_misses
);

    localparam int IDX_W = idx_w(SETS);
    localparam int TAG_W = tag_w(SETS);
    localparam int WAY_W = way_w(WAYS);

    state_t state, next_state;

    logic              valid [WAYS][SETS];
    logic              dirty [WAYS][SETS];
    logic [TAG_W-1:0]  tags  [WAYS][SETS];
    logic [LINE_W-1:0] lines [WAYS][SETS];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag_in;
    logic [1:0]        woff;
    logic              req, hit, found_inv;
    logic [WAY_W-1:0]  hit_way, miss_victim, plru_victim, victim_q;
    logic [LINE_W-1:0] hit_line, merged_line;
    logic              plru_touch, count_hit, count_miss;
    // replay: first IDLE cycle after a fill; wt_done: first IDLE cycle after a write-through
    logic              replay, wt_done;
    logic [STAT_W-1:0] hits_q, misses_q;

    assign idx    = proc_addr[2+IDX_W-1:2];
    assign tag_in = proc_addr[29:2+IDX_W];
    assign woff   = proc_addr[1:0];
    assign req    = proc_read | proc_write;

    always_comb begin
        hit         = 1'b0;
        hit_way     = '0;
        found_inv   = 1'b0;
        miss_victim = plru_victim;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid[w][idx] && tags[w][idx] == tag_in) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid[w][idx] && !found_inv) begin
                found_inv   = 1'b1;
                miss_victim = WAY_W'(w);
            end
        end
        hit_line    = lines[hit_way][idx];
        merged_line = hit_line;
        merged_line[{woff, 5'b0} +: WORD_W] = proc_wdata;
    end

    assign proc_rdata = hit_line[{woff, 5'b0} +: WORD_W];

    cache_plru #(.WAYS(WAYS), .SETS(SETS)) u_plru (
        .clk        (clk),
        .rst_n      (rst_n),
        .touch      (plru_touch),
        .set_idx    (idx),
        .touch_way  (hit_way),
        .victim_way (plru_victim)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        proc_stall = 1'b0;
        plru_touch = 1'b0;
        count_hit  = 1'b0;
        count_miss = 1'b0;
        case (state)
            IDLE: if (req) begin
                if (hit) begin
                    plru_touch = 1'b1;
                    count_hit  = !replay && !wt_done;
                    if (proc_write && WRITE_BACK == 0 && !wt_done) begin
                        next_state = WTHRU;
                        proc_stall = 1'b1;
                    end
                end else begin
                    proc_stall = 1'b1;
                    count_miss = 1'b1;
                    if (WRITE_BACK != 0 && valid[miss_victim][idx] && dirty[miss_victim][idx])
                        next_state = WBACK;
                    else
                        next_state = FILL;
                end
            end
            WBACK: begin
                proc_stall = 1'b1;
                if (mem_ready) next_state = FILL;
            end
            FILL: begin
                proc_stall = 1'b1;
                if (mem_ready) next_state = IDLE;
            end
            WTHRU: begin
                proc_stall = 1'b1;
                if (mem_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (!rst_n) proc_stall = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            victim_q  <= '0;
            replay    <= 1'b0;
            wt_done   <= 1'b0;
            hits_q    <= '0;
            misses_q  <= '0;
            for (int unsigned w = 0; w < WAYS; w++) begin
                for (int unsigned s = 0; s < SETS; s++) begin
                    valid[w][s] <= 1'b0;
                    dirty[w][s] <= 1'b0;
                end
            end
        end else begin
            replay  <= (state == FILL) && mem_ready;
            wt_done <= (state == WTHRU) && mem_ready;
            if (count_hit && hits_q != '1)    hits_q   <= hits_q + 1'b1;
            if (count_miss && misses_q != '1) misses_q <= misses_q + 1'b1;
            case (state)
                IDLE: if (req) begin
                    if (hit) begin
                        if (proc_write && WRITE_BACK != 0) dirty[hit_way][idx] <= 1'b1;
                        if (next_state == WTHRU) begin
                            mem_write <= 1'b1;
                            mem_addr  <= proc_addr[29:2];
                            mem_wdata <= merged_line;
                        end
                    end else begin
                        victim_q <= miss_victim;
                        if (next_state == WBACK) begin
                            mem_write <= 1'b1;
                            mem_addr  <= {tags[miss_victim][idx], idx};
                            mem_wdata <= lines[miss_victim][idx];
                        end else begin
                            mem_read <= 1'b1;
                            mem_addr <= proc_addr[29:2];
                        end
                    end
                end
                WBACK: if (mem_ready) begin
                    mem_write              <= 1'b0;
                    dirty[victim_q][idx]   <= 1'b0;
                    mem_read               <= 1'b1;
                    mem_addr               <= proc_addr[29:2];
                end
                FILL: if (mem_ready) begin
                    mem_read               <= 1'b0;
                    valid[victim_q][idx]   <= 1'b1;
                    dirty[victim_q][idx]   <= 1'b0;
                end
                WTHRU: if (mem_ready) mem_write <= 1'b0;
                default: ;
            endcase
        end
    end

    // Line payload and tags carry no reset; valid bits gate every use of them.
    always_ff @(posedge clk) begin
        if (rst_n && state == IDLE && req && hit && proc_write)
            lines[hit_way][idx] <= merged_line;
        if (rst_n && state == FILL && mem_ready) begin
            lines[victim_q][idx] <= mem_rdata;
            tags[victim_q][idx]  <= tag_in;
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;

endmodule

// File: tb/tb_assoc_wb_cache.sv
// Bench for assoc_wb_cache: a write-back and a write-through instance driven by directed
// and random accesses, checked against a flat-memory plus true-LRU cache model.
module tb_assoc_wb_cache;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         p_read [2];
    logic         p_write [2];
    logic [29:0]  p_addr [2];
    logic [31:0]  p_wdata [2];
    logic [31:0]  p_rdata [2];
    logic         p_stall [2];
    logic         m_read [2];
    logic         m_write [2];
    logic [27:0]  m_addr [2];
    logic [127:0] m_wdata [2];
    logic [127:0] m_rdata [2];
    logic         m_ready [2];
    logic [31:0]  s_hits [2];
    logic [31:0]  s_misses [2];

    assoc_wb_cache #(.WAYS(2), .SETS(8), .WRITE_BACK(1), .STAT_W(32)) dut_wb (
        .clk(clk), .rst_n(rst_n),
        .proc_read(p_read[0]), .proc_write(p_write[0]), .proc_addr(p_addr[0]),
        .proc_wdata(p_wdata[0]), .proc_rdata(p_rdata[0]), .proc_stall(p_stall[0]),
        .mem_read(m_read[0]), .mem_write(m_write[0]), .mem_addr(m_addr[0]),
        .mem_wdata(m_wdata[0]), .mem_rdata(m_rdata[0]), .mem_ready(m_ready[0]),
        .stat_hits(s_hits[0]), .stat_misses(s_misses[0])
    );

    assoc_wb_cache #(.WAYS(2), .SETS(8), .WRITE_BACK(0), .STAT_W(32)) dut_wt (
        .clk(clk), .rst_n(rst_n),
        .proc_read(p_read[1]), .proc_write(p_write[1]), .proc_addr(p_addr[1]),
        .proc_wdata(p_wdata[1]), .proc_rdata(p_rdata[1]), .proc_stall(p_stall[1]),
        .mem_read(m_read[1]), .mem_write(m_write[1]), .mem_addr(m_addr[1]),
        .mem_wdata(m_wdata[1]), .mem_rdata(m_rdata[1]), .mem_ready(m_ready[1]),
        .stat_hits(s_hits[1]), .stat_misses(s_misses[1])
    );

    // ---------------- backing memory: 64 lines per instance ----------------
    logic [127:0] bmem [2][64];
    bit           mem_init = 1'b0;
    int           lat [2];
    bit           hold [2];
    int           cnt [2]   = '{0, 0};
    int           n_rd [2]  = '{0, 0};
    int           n_wr [2]  = '{0, 0};
    logic [27:0]  last_raddr [2];
    logic [27:0]  last_waddr [2];
    logic [127:0] last_wdata [2];

    function automatic logic [31:0] init_word(input int d, input int la, input int k);
        return 32'(32'hC000_0000 + d * 32'h0010_0000 + la * 256 + k);
    endfunction

    always @(negedge clk) begin
        if (!mem_init) begin
            for (int d = 0; d < 2; d++)
                for (int la = 0; la < 64; la++)
                    for (int k = 0; k < 4; k++)
                        bmem[d][la][k*32 +: 32] = init_word(d, la, k);
            mem_init = 1'b1;
        end
        for (int d = 0; d < 2; d++) begin
            m_ready[d] = 1'b0;
            if (!rst_n) begin
                cnt[d] = 0;
            end else if ((m_read[d] || m_write[d]) && !hold[d]) begin
                cnt[d]++;
                if (cnt[d] >= lat[d]) begin
                    cnt[d]     = 0;
                    m_ready[d] = 1'b1;
                    if (m_write[d]) begin
                        bmem[d][m_addr[d][5:0]] = m_wdata[d];
                        n_wr[d]++;
                        last_waddr[d] = m_addr[d];
                        last_wdata[d] = m_wdata[d];
                    end else begin
                        m_rdata[d] = bmem[d][m_addr[d][5:0]];
                        n_rd[d]++;
                        last_raddr[d] = m_addr[d];
                    end
                end
            end
        end
    end

    // ---------------- reference model ----------------
    bit          mv [2][8][2];
    bit          md [2][8][2];
    int          mt [2][8][2];
    int          mru [2][8];
    logic [31:0] gold [2][256];
    logic [31:0] exp_hits [2];
    logic [31:0] exp_miss [2];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            exp_hits[d] = '0;
            exp_miss[d] = '0;
            for (int s = 0; s < 8; s++) begin
                mru[d][s] = 0;
                for (int w = 0; w < 2; w++) begin
                    mv[d][s][w] = 1'b0;
                    md[d][s][w] = 1'b0;
                end
            end
        end
    endtask

    function automatic logic [127:0] gold_line(input int d, input int la);
        logic [127:0] r;
        for (int k = 0; k < 4; k++) r[k*32 +: 32] = gold[d][la*4 + k];
        return r;
    endfunction

    task automatic access(input int d, input bit wr, input logic [29:0] addr, input logic [31:0] wdata);
        int sidx, tag, la, way, vic, exp_cyc, cyc, rd0, wr0, exp_rd, exp_wr;
        bit hit, wb;
        logic [27:0]  exp_waddr;
        logic [127:0] exp_wline;
        wb        = (d == 0);
        sidx      = int'(addr[4:2]);
        tag       = int'(addr[29:5]);
        la        = int'(addr[29:2]);
        hit       = 1'b0;
        way       = 0;
        exp_rd    = 0;
        exp_wr    = 0;
        exp_cyc   = 0;
        exp_waddr = '0;
        exp_wline = '0;
        for (int w = 0; w < 2; w++)
            if (mv[d][sidx][w] && mt[d][sidx][w] == tag) begin
                hit = 1'b1;
                way = w;
            end
        if (hit) begin
            if (exp_hits[d] != 32'hFFFF_FFFF) exp_hits[d]++;
        end else begin
            if (exp_miss[d] != 32'hFFFF_FFFF) exp_miss[d]++;
            exp_rd  = 1;
            exp_cyc = 1 + lat[d];
            vic = !mv[d][sidx][0] ? 0 : (!mv[d][sidx][1] ? 1 : 1 - mru[d][sidx]);
            if (wb && mv[d][sidx][vic] && md[d][sidx][vic]) begin
                exp_wr    = 1;
                exp_waddr = 28'(mt[d][sidx][vic] * 8 + sidx);
                exp_wline = gold_line(d, mt[d][sidx][vic] * 8 + sidx);
                exp_cyc  += lat[d];
            end
            mv[d][sidx][vic] = 1'b1;
            md[d][sidx][vic] = 1'b0;
            mt[d][sidx][vic] = tag;
            way = vic;
        end
        mru[d][sidx] = way;
        if (wr) begin
            gold[d][addr[7:0]] = wdata;
            if (wb) begin
                md[d][sidx][way] = 1'b1;
            end else begin
                exp_wr    = 1;
                exp_waddr = 28'(la);
                exp_wline = gold_line(d, la);
                exp_cyc  += 1 + lat[d];
            end
        end

        rd0 = n_rd[d];
        wr0 = n_wr[d];
        p_addr[d]  = addr;
        p_wdata[d] = wdata;
        p_write[d] = wr;
        p_read[d]  = !wr;
        cyc = 0;
        #1;
        while (p_stall[d] && cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("stall_cycles", 128'(cyc), 128'(exp_cyc));
        if (!wr) check("rdata", p_rdata[d], gold[d][addr[7:0]]);
        @(negedge clk);
        p_read[d]  = 1'b0;
        p_write[d] = 1'b0;
        check("mem_reads", 128'(n_rd[d] - rd0), 128'(exp_rd));
        check("mem_writes", 128'(n_wr[d] - wr0), 128'(exp_wr));
        if (exp_rd == 1) check("fill_addr", last_raddr[d], 28'(la));
        if (exp_wr == 1) begin
            check("write_addr", last_waddr[d], exp_waddr);
            check("write_line", last_wdata[d], exp_wline);
        end
        check("stat_hits", s_hits[d], exp_hits[d]);
        check("stat_misses", s_misses[d], exp_miss[d]);
    endtask

    task automatic resync_gold();
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 256; w++)
                gold[d][w] = bmem[d][w / 4][(w % 4) * 32 +: 32];
    endtask

    // ---------------- directed and random sequence ----------------
    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            p_read[d]  = 1'b0;
            p_write[d] = 1'b0;
            p_addr[d]  = '0;
            p_wdata[d] = '0;
            hold[d]    = 1'b0;
            lat[d]     = 3;
            for (int w = 0; w < 256; w++) gold[d][w] = init_word(d, w / 4, w % 4);
        end
        model_reset();

        // reset state, with a request present on the write-back instance
        p_read[0] = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("stall_in_reset", p_stall[0], 1'b0);
        for (int d = 0; d < 2; d++) begin
            check("rst_mem_read", m_read[d], 1'b0);
            check("rst_mem_write", m_write[d], 1'b0);
            check("rst_mem_addr", m_addr[d], 28'h0);
            check("rst_mem_wdata", m_wdata[d], 128'h0);
            check("rst_hits", s_hits[d], 32'h0);
            check("rst_misses", s_misses[d], 32'h0);
        end
        p_read[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // cold read then immediate re-read of the neighbouring word
        access(0, 1'b0, 30'h010, '0);
        check("cold_rdata_A", p_rdata[0], init_word(0, 4, 0));
        access(0, 1'b0, 30'h011, '0);

        // dirty eviction in set 0
        lat[0] = 2;
        access(0, 1'b1, 30'h000, 32'hDEAD_BEEF);
        access(0, 1'b0, 30'h020, '0);
        access(0, 1'b0, 30'h040, '0);
        check("evict_addr", last_waddr[0], 28'h0);
        check("evict_word0", last_wdata[0][31:0], 32'hDEAD_BEEF);

        // write-through hit and later clean eviction
        lat[1] = 2;
        access(1, 1'b0, 30'h000, '0);
        access(1, 1'b1, 30'h001, 32'h1234_5678);
        check("wthru_addr", last_waddr[1], 28'h0);
        check("wthru_word1", last_wdata[1][63:32], 32'h1234_5678);
        access(1, 1'b0, 30'h020, '0);
        access(1, 1'b0, 30'h040, '0);

        // reset while a fill is outstanding
        hold[0]   = 1'b1;
        p_addr[0] = 30'h0A8;
        p_read[0] = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("fill_pending", m_read[0], 1'b1);
        check("fill_stall", p_stall[0], 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("stall_low_rst", p_stall[0], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_mem_read", m_read[0], 1'b0);
        check("abort_mem_write", m_write[0], 1'b0);
        p_read[0] = 1'b0;
        hold[0]   = 1'b0;
        model_reset();
        resync_gold();
        @(negedge clk);
        access(0, 1'b0, 30'h0A8, '0);

        // hit counter saturation
        dut_wb.hits_q = 32'hFFFF_FFFF;
        exp_hits[0]   = 32'hFFFF_FFFF;
        access(0, 1'b0, 30'h0A9, '0);
        check("hits_saturated", s_hits[0], 32'hFFFF_FFFF);

        // random traffic on both instances
        for (int i = 0; i < 160; i++) begin
            int d;
            d = int'($urandom_range(0, 1));
            lat[d] = int'($urandom_range(1, 4));
            access(d, ($urandom_range(0, 9) < 4), 30'($urandom_range(0, 255)), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
